// File: rtl/ysyx_22040237_lsu_pkg.sv
// Shared widths, ls_info bit positions, size masks, FSM encoding and memory request payload
// for the ysyx_22040237 load/store unit.
package ysyx_22040237_lsu_pkg;

  localparam int unsigned ADDR_W      = 64;
  localparam int unsigned DATA_W      = 64;
  localparam int unsigned STRB_W      = DATA_W / 8;
  localparam int unsigned INFO_W      = 7;
  localparam int unsigned RD_IDX_W    = 5;
  localparam int unsigned SIZE_W      = 4;
  localparam int unsigned WD_W        = 8;
  localparam int unsigned TIMEOUT_CYC = 255;

  localparam int unsigned INFO_LOAD  = 0;
  localparam int unsigned INFO_STORE = 1;
  localparam int unsigned INFO_USIGN = 2;
  localparam int unsigned INFO_BYTE  = 3;
  localparam int unsigned INFO_DB    = 4;
  localparam int unsigned INFO_WORD  = 5;
  localparam int unsigned INFO_DW    = 6;

  localparam logic [STRB_W-1:0] MASK_B = 8'h01;
  localparam logic [STRB_W-1:0] MASK_H = 8'h03;
  localparam logic [STRB_W-1:0] MASK_W = 8'h0F;
  localparam logic [STRB_W-1:0] MASK_D = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_WB   = 2'd3
  } lsu_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              wen;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wmask;
  } mem_req_t;

  function automatic logic is_onehot(input logic [SIZE_W-1:0] v);
    return (v != '0) && ((v & (v - SIZE_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/ysyx_22040237_lsu_align.sv
// Combinational byte-lane helper: store shift and strobe, load extract and extend,
// size legality and natural-alignment check. size_i is {dw, word, half, byte}.
module ysyx_22040237_lsu_align
  import ysyx_22040237_lsu_pkg::*;
(
  input  logic [2:0]        addr_lo_i,
  input  logic [SIZE_W-1:0] size_i,
  input  logic              usign_i,
  input  logic [DATA_W-1:0] st_data_i,
  input  logic [DATA_W-1:0] ld_rdata_i,
  output logic [STRB_W-1:0] wmask_c_o,
  output logic [DATA_W-1:0] wdata_c_o,
  output logic [DATA_W-1:0] ld_data_c_o,
  output logic              misalign_c_o,
  output logic              size_err_c_o
);

  logic [5:0]        shamt;
  logic [STRB_W-1:0] size_mask;
  logic [DATA_W-1:0] shifted;
  logic              sext;

  assign shamt        = {addr_lo_i, 3'b000};
  assign sext         = ~usign_i;
  assign size_err_c_o = ~is_onehot(size_i);
  assign wmask_c_o    = size_mask << addr_lo_i;
  assign wdata_c_o    = st_data_i << shamt;
  assign shifted      = ld_rdata_i >> shamt;

  // Size mask and natural-alignment check
  always_comb begin
    size_mask    = '0;
    misalign_c_o = 1'b0;
    if (size_i[0]) begin
      size_mask = MASK_B;
    end else if (size_i[1]) begin
      size_mask    = MASK_H;
      misalign_c_o = addr_lo_i[0];
    end else if (size_i[2]) begin
      size_mask    = MASK_W;
      misalign_c_o = |addr_lo_i[1:0];
    end else if (size_i[3]) begin
      size_mask    = MASK_D;
      misalign_c_o = |addr_lo_i;
    end
  end

  // Truncate the lane-aligned read data to the access size and extend
  always_comb begin
    ld_data_c_o = shifted;
    if (size_i[0]) begin
      ld_data_c_o = {{56{sext & shifted[7]}}, shifted[7:0]};
    end else if (size_i[1]) begin
      ld_data_c_o = {{48{sext & shifted[15]}}, shifted[15:0]};
    end else if (size_i[2]) begin
      ld_data_c_o = {{32{sext & shifted[31]}}, shifted[31:0]};
    end
  end

endmodule

// File: rtl/ysyx_22040237_lsu.sv
// Load/store unit: captures one execute request, runs a valid/ready data-memory access and
// returns one write-back beat. Optional watchdog: YSYX_22040237_LSU_WATCHDOG_EN.
module ysyx_22040237_lsu
  import ysyx_22040237_lsu_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                ls_valid_i,
  output logic                ls_ready_o,
  input  logic [INFO_W-1:0]   ls_info_bus_i,
  input  logic [ADDR_W-1:0]   alu_res_i,
  input  logic [DATA_W-1:0]   rs2_store_i,
  input  logic                rd_wr_en_i,
  input  logic [RD_IDX_W-1:0] rd_idx_i,
  output logic                mem_req_valid_o,
  input  logic                mem_req_ready_i,
  output logic [ADDR_W-1:0]   mem_req_addr_o,
  output logic                mem_req_wen_o,
  output logic [DATA_W-1:0]   mem_req_wdata_o,
  output logic [STRB_W-1:0]   mem_req_wmask_o,
  input  logic                mem_rsp_valid_i,
  input  logic [DATA_W-1:0]   mem_rsp_rdata_i,
  output logic                wb_valid_o,
  output logic                wb_rd_wr_en_o,
  output logic [RD_IDX_W-1:0] wb_rd_idx_o,
  output logic [DATA_W-1:0]   wb_data_o,
  output logic                err_o
);

  lsu_state_e          state_q, state_d;
  logic                ld_q, ld_d;
  logic [2:0]          addr_lo_q, addr_lo_d;
  logic [SIZE_W-1:0]   size_q, size_d;
  logic                usign_q, usign_d;
  logic                rd_wr_en_q, rd_wr_en_d;
  logic [RD_IDX_W-1:0] rd_idx_q, rd_idx_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   result_q, result_d;
  mem_req_t            req_q, req_d;
  logic                req_valid_q, req_valid_d;
  logic                ls_ready_q, ls_ready_d;
  logic                wb_valid_q, wb_valid_d;
  logic                wb_rd_wr_en_q, wb_rd_wr_en_d;
  logic [RD_IDX_W-1:0] wb_rd_idx_q, wb_rd_idx_d;
  logic [DATA_W-1:0]   wb_data_q, wb_data_d;
  logic                wb_err_q, wb_err_d;
`ifdef YSYX_22040237_LSU_WATCHDOG_EN
  logic [WD_W-1:0]     wd_cnt_q, wd_cnt_d;
`endif

  logic              in_ld, in_st, in_usign, idle;
  logic [SIZE_W-1:0] in_size;
  logic [2:0]        al_addr_lo;
  logic [SIZE_W-1:0] al_size;
  logic              al_usign;
  logic [STRB_W-1:0] wmask_c;
  logic [DATA_W-1:0] wdata_c, ld_data_c;
  logic              misalign_c, size_err_c;

  assign in_ld    = ls_info_bus_i[INFO_LOAD];
  assign in_st    = ls_info_bus_i[INFO_STORE];
  assign in_usign = ls_info_bus_i[INFO_USIGN];
  assign in_size  = {ls_info_bus_i[INFO_DW], ls_info_bus_i[INFO_WORD],
                     ls_info_bus_i[INFO_DB], ls_info_bus_i[INFO_BYTE]};
  assign idle     = (state_q == ST_IDLE);

  // The aligner sees live inputs while accepting, captured fields while the load is in flight
  assign al_addr_lo = idle ? alu_res_i[2:0] : addr_lo_q;
  assign al_size    = idle ? in_size : size_q;
  assign al_usign   = idle ? in_usign : usign_q;

  ysyx_22040237_lsu_align u_align (
    .addr_lo_i    (al_addr_lo),
    .size_i       (al_size),
    .usign_i      (al_usign),
    .st_data_i    (rs2_store_i),
    .ld_rdata_i   (mem_rsp_rdata_i),
    .wmask_c_o    (wmask_c),
    .wdata_c_o    (wdata_c),
    .ld_data_c_o  (ld_data_c),
    .misalign_c_o (misalign_c),
    .size_err_c_o (size_err_c)
  );

  // Next-state and registered-output logic
  always_comb begin
    state_d       = state_q;
    ld_d          = ld_q;
    addr_lo_d     = addr_lo_q;
    size_d        = size_q;
    usign_d       = usign_q;
    rd_wr_en_d    = rd_wr_en_q;
    rd_idx_d      = rd_idx_q;
    err_d         = err_q;
    result_d      = result_q;
    req_d         = req_q;
    wb_valid_d    = 1'b0;
    wb_err_d      = 1'b0;
    wb_rd_wr_en_d = 1'b0;
    wb_rd_idx_d   = wb_rd_idx_q;
    wb_data_d     = wb_data_q;
`ifdef YSYX_22040237_LSU_WATCHDOG_EN
    wd_cnt_d      = wd_cnt_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (ls_valid_i) begin
          ld_d       = in_ld;
          addr_lo_d  = alu_res_i[2:0];
          size_d     = in_size;
          usign_d    = in_usign;
          rd_idx_d   = rd_idx_i;
          rd_wr_en_d = rd_wr_en_i;
          result_d   = alu_res_i;
          err_d      = 1'b0;
          if (!in_ld && !in_st) begin
            state_d = ST_WB;
          end else if ((in_ld && in_st) || size_err_c || misalign_c) begin
            err_d      = 1'b1;
            rd_wr_en_d = 1'b0;
            state_d    = ST_WB;
          end else begin
            req_d.addr  = {alu_res_i[ADDR_W-1:3], 3'b000};
            req_d.wen   = in_st;
            req_d.wmask = in_st ? wmask_c : '0;
            req_d.wdata = in_st ? wdata_c : '0;
            if (in_st) rd_wr_en_d = 1'b0;
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (mem_req_ready_i) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (mem_rsp_valid_i) begin
          state_d = ST_WB;
          if (ld_q) result_d = ld_data_c;
        end
      end
      ST_WB: begin
        state_d       = ST_IDLE;
        wb_valid_d    = 1'b1;
        wb_err_d      = err_q;
        wb_rd_wr_en_d = rd_wr_en_q;
        wb_rd_idx_d   = rd_idx_q;
        wb_data_d     = result_q;
      end
      default: state_d = ST_IDLE;
    endcase
`ifdef YSYX_22040237_LSU_WATCHDOG_EN
    // Abandon a stuck access; the timeout takes priority over a same-cycle handshake
    if (state_q == ST_REQ || state_q == ST_WAIT) begin
      wd_cnt_d = wd_cnt_q + WD_W'(1);
      if (wd_cnt_q == WD_W'(TIMEOUT_CYC)) begin
        state_d    = ST_WB;
        err_d      = 1'b1;
        rd_wr_en_d = 1'b0;
      end
    end
    if (idle && state_d == ST_REQ) wd_cnt_d = '0;
`endif
    req_valid_d = (state_d == ST_REQ);
    ls_ready_d  = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      ld_q          <= 1'b0;
      addr_lo_q     <= '0;
      size_q        <= '0;
      usign_q       <= 1'b0;
      rd_wr_en_q    <= 1'b0;
      rd_idx_q      <= '0;
      err_q         <= 1'b0;
      result_q      <= '0;
      req_q         <= '0;
      req_valid_q   <= 1'b0;
      ls_ready_q    <= 1'b1;
      wb_valid_q    <= 1'b0;
      wb_rd_wr_en_q <= 1'b0;
      wb_rd_idx_q   <= '0;
      wb_data_q     <= '0;
      wb_err_q      <= 1'b0;
`ifdef YSYX_22040237_LSU_WATCHDOG_EN
      wd_cnt_q      <= '0;
`endif
    end else begin
      state_q       <= state_d;
      ld_q          <= ld_d;
      addr_lo_q     <= addr_lo_d;
      size_q        <= size_d;
      usign_q       <= usign_d;
      rd_wr_en_q    <= rd_wr_en_d;
      rd_idx_q      <= rd_idx_d;
      err_q         <= err_d;
      result_q      <= result_d;
      req_q         <= req_d;
      req_valid_q   <= req_valid_d;
      ls_ready_q    <= ls_ready_d;
      wb_valid_q    <= wb_valid_d;
      wb_rd_wr_en_q <= wb_rd_wr_en_d;
      wb_rd_idx_q   <= wb_rd_idx_d;
      wb_data_q     <= wb_data_d;
      wb_err_q      <= wb_err_d;
`ifdef YSYX_22040237_LSU_WATCHDOG_EN
      wd_cnt_q      <= wd_cnt_d;
`endif
    end
  end

  assign ls_ready_o      = ls_ready_q;
  assign mem_req_valid_o = req_valid_q;
  assign mem_req_addr_o  = req_q.addr;
  assign mem_req_wen_o   = req_q.wen;
  assign mem_req_wdata_o = req_q.wdata;
  assign mem_req_wmask_o = req_q.wmask;
  assign wb_valid_o      = wb_valid_q;
  assign wb_rd_wr_en_o   = wb_rd_wr_en_q;
  assign wb_rd_idx_o     = wb_rd_idx_q;
  assign wb_data_o       = wb_data_q;
  assign err_o           = wb_err_q;

endmodule

// File: tb/tb_ysyx_22040237_lsu.sv
// Self-checking bench for ysyx_22040237_lsu: directed scenarios plus randomized requests
// checked against a byte-arithmetic reference model.
module tb_ysyx_22040237_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        ls_valid, ls_ready;
  logic [6:0]  ls_info;
  logic [63:0] alu_res, rs2_store;
  logic        rd_wr_en;
  logic [4:0]  rd_idx;
  logic        mem_req_valid, mem_req_ready, mem_req_wen;
  logic [63:0] mem_req_addr, mem_req_wdata;
  logic [7:0]  mem_req_wmask;
  logic        mem_rsp_valid;
  logic [63:0] mem_rsp_rdata;
  logic        wb_valid, wb_rd_wr_en, err;
  logic [4:0]  wb_rd_idx;
  logic [63:0] wb_data;

  int tests = 0;
  int fails = 0;

  // Observations of the most recent transaction
  bit          obs_req_seen, obs_stable, obs_ready_low, obs_wb_seen, obs_wen, obs_wb_en, obs_err;
  logic [63:0] obs_addr, obs_wdata, obs_wb_data;
  logic [7:0]  obs_mask;
  logic [4:0]  obs_wb_idx;
  int          obs_lat, obs_req_cyc;

  always #5 clk = ~clk;

  ysyx_22040237_lsu dut (
    .clk             (clk),
    .rst             (rst),
    .ls_valid_i      (ls_valid),
    .ls_ready_o      (ls_ready),
    .ls_info_bus_i   (ls_info),
    .alu_res_i       (alu_res),
    .rs2_store_i     (rs2_store),
    .rd_wr_en_i      (rd_wr_en),
    .rd_idx_i        (rd_idx),
    .mem_req_valid_o (mem_req_valid),
    .mem_req_ready_i (mem_req_ready),
    .mem_req_addr_o  (mem_req_addr),
    .mem_req_wen_o   (mem_req_wen),
    .mem_req_wdata_o (mem_req_wdata),
    .mem_req_wmask_o (mem_req_wmask),
    .mem_rsp_valid_i (mem_rsp_valid),
    .mem_rsp_rdata_i (mem_rsp_rdata),
    .wb_valid_o      (wb_valid),
    .wb_rd_wr_en_o   (wb_rd_wr_en),
    .wb_rd_idx_o     (wb_rd_idx),
    .wb_data_o       (wb_data),
    .err_o           (err)
  );

  function automatic void ref_model(input logic [6:0] info, input logic [63:0] addr,
                                    input logic [63:0] rs2, input logic [63:0] rdata,
                                    input logic rd_en, output bit is_mem, output bit e_err,
                                    output bit e_wben, output logic [63:0] e_data,
                                    output logic [7:0] e_mask, output logic [63:0] e_wdata);
    int nb, off;
    longint unsigned v, lim;
    off = int'(addr % 64'd8);
    nb = info[3] ? 1 : info[4] ? 2 : info[5] ? 4 : 8;
    is_mem = 0; e_err = 0; e_wben = rd_en; e_data = addr; e_mask = '0; e_wdata = '0;
    if (!info[0] && !info[1]) return;
    if ((info[0] && info[1]) || $countones(info[6:3]) != 1 || (off % nb) != 0) begin
      e_err = 1; e_wben = 0;
      return;
    end
    is_mem = 1;
    if (info[1]) begin
      e_mask  = 8'(((1 << nb) - 1) << off);
      e_wdata = rs2 << (8 * off);
      e_wben  = 0;
    end else begin
      v = rdata >> (8 * off);
      if (nb < 8) begin
        lim = (64'd1 << (8 * nb)) - 64'd1;
        v = v & lim;
        if (!info[2] && v[8*nb-1]) v = v | ~lim;
      end
      e_data = v;
    end
  endfunction

  // Drives one request and plays the memory side; records what the DUT did
  task automatic run_txn(input logic [6:0] info, input logic [63:0] addr, input logic [63:0] rs2,
                         input logic [63:0] rdata, input logic rd_en, input logic [4:0] idx,
                         input int req_wait, input int rsp_wait);
    int cyc, rq_cnt, rs_cnt;
    bit hs_set, in_wait, rsp_done;
    obs_req_seen = 0; obs_stable = 1; obs_ready_low = 1; obs_wb_seen = 0; obs_lat = -1;
    obs_req_cyc = 0; obs_wen = 0; obs_wb_en = 0; obs_err = 0;
    cyc = 0; rq_cnt = 0; rs_cnt = 0; hs_set = 0; in_wait = 0; rsp_done = 0;
    @(negedge clk);
    ls_info = info; alu_res = addr; rs2_store = rs2; rd_wr_en = rd_en; rd_idx = idx; ls_valid = 1;
    @(posedge clk); #1;
    ls_valid = 0; ls_info = 7'($urandom); alu_res = {$urandom, $urandom};
    rs2_store = {$urandom, $urandom}; rd_idx = 5'($urandom); rd_wr_en = 1'($urandom);
    while (!obs_wb_seen && cyc < 400) begin
      @(negedge clk);
      cyc++;
      mem_rsp_valid = 0;
      mem_rsp_rdata = {$urandom, $urandom};
      if (hs_set) begin hs_set = 0; in_wait = 1; mem_req_ready = 0; end
      if (mem_req_valid) begin
        if (!obs_req_seen) begin
          obs_req_seen = 1; obs_addr = mem_req_addr; obs_wen = mem_req_wen;
          obs_mask = mem_req_wmask; obs_wdata = mem_req_wdata;
        end else if (mem_req_addr !== obs_addr || mem_req_wen !== obs_wen ||
                     mem_req_wmask !== obs_mask || mem_req_wdata !== obs_wdata) begin
          obs_stable = 0;
        end
        obs_req_cyc++;
        if (rq_cnt >= req_wait) begin mem_req_ready = 1; hs_set = 1; end
        else mem_req_ready = 0;
        rq_cnt++;
      end
      if (in_wait && !rsp_done) begin
        if (rs_cnt >= rsp_wait) begin mem_rsp_valid = 1; mem_rsp_rdata = rdata; rsp_done = 1; end
        else rs_cnt++;
      end
      if (wb_valid) begin
        obs_wb_seen = 1; obs_lat = cyc; obs_wb_en = wb_rd_wr_en; obs_wb_idx = wb_rd_idx;
        obs_wb_data = wb_data; obs_err = err;
      end else if (ls_ready) begin
        obs_ready_low = 0;
      end
    end
    mem_req_ready = 0;
    mem_rsp_valid = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++; if (ls_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", ls_ready); end
    tests++; if ({mem_req_valid, mem_req_wen, wb_valid, wb_rd_wr_en, err} !== 5'b0) begin
      fails++; $display("FAIL reset_ctrl: got %b want 00000", {mem_req_valid, mem_req_wen, wb_valid, wb_rd_wr_en, err});
    end
    tests++; if ({mem_req_addr, mem_req_wdata, mem_req_wmask, wb_rd_idx, wb_data} !== '0) begin
      fails++; $display("FAIL reset_data: addr=%h wdata=%h mask=%h idx=%0d data=%h want all 0",
                        mem_req_addr, mem_req_wdata, mem_req_wmask, wb_rd_idx, wb_data);
    end
    rst = 0;
  endtask

  task automatic test_store_sb();
    run_txn(7'h0A, 64'h8000_0005, 64'hAB, 64'h0, 1'b1, 5'd3, 1, 1);
    tests++; if (obs_addr !== 64'h8000_0000) begin fails++; $display("FAIL sb_addr: got %h want 80000000", obs_addr); end
    tests++; if (obs_mask !== 8'h20) begin fails++; $display("FAIL sb_wmask: got %h want 20", obs_mask); end
    tests++; if (obs_wdata !== 64'h0000_AB00_0000_0000) begin fails++; $display("FAIL sb_wdata: got %h want 0000ab0000000000", obs_wdata); end
    tests++; if (obs_wen !== 1'b1) begin fails++; $display("FAIL sb_wen: got %b want 1", obs_wen); end
    tests++; if (!obs_wb_seen || obs_wb_en !== 1'b0 || obs_err !== 1'b0) begin
      fails++; $display("FAIL sb_wb: seen=%b rd_wr_en=%b err=%b want 1 0 0", obs_wb_seen, obs_wb_en, obs_err);
    end
    tests++; if (obs_lat != 6) begin fails++; $display("FAIL sb_latency: got %0d want 6", obs_lat); end
  endtask

  task automatic test_load_ext();
    run_txn(7'h09, 64'h8000_1003, 64'h0, 64'h0000_0000_8000_0000, 1'b1, 5'd9, 0, 0);
    tests++; if (obs_wb_data !== 64'hFFFF_FFFF_FFFF_FF80 || obs_wb_en !== 1'b1) begin
      fails++; $display("FAIL lb_sext: got %h en=%b want ffffffffffffff80 en=1", obs_wb_data, obs_wb_en);
    end
    tests++; if (obs_mask !== 8'h00 || obs_wen !== 1'b0) begin
      fails++; $display("FAIL lb_req: mask=%h wen=%b want 00 0", obs_mask, obs_wen);
    end
    run_txn(7'h0D, 64'h8000_1003, 64'h0, 64'h0000_0000_8000_0000, 1'b1, 5'd9, 0, 2);
    tests++; if (obs_wb_data !== 64'h80) begin fails++; $display("FAIL lbu_zext: got %h want 80", obs_wb_data); end
  endtask

  task automatic test_misaligned();
    run_txn(7'h21, 64'h8000_0002, 64'h0, 64'h0, 1'b1, 5'd4, 0, 0);
    tests++; if (obs_req_seen) begin fails++; $display("FAIL lw_misalign_req: got request want none"); end
    tests++; if (!obs_wb_seen || obs_err !== 1'b1 || obs_wb_en !== 1'b0) begin
      fails++; $display("FAIL lw_misalign_wb: seen=%b err=%b rd_wr_en=%b want 1 1 0", obs_wb_seen, obs_err, obs_wb_en);
    end
    tests++; if (obs_lat != 2) begin fails++; $display("FAIL lw_misalign_latency: got %0d want 2", obs_lat); end
  endtask

  task automatic test_stall();
    run_txn(7'h41, 64'h0000_0000_8000_0040, 64'h0, 64'h1122_3344_5566_7788, 1'b1, 5'd12, 5, 0);
    tests++; if (!obs_stable || obs_req_cyc != 6) begin
      fails++; $display("FAIL ld_stall_req: stable=%b cycles=%0d want 1 6", obs_stable, obs_req_cyc);
    end
    tests++; if (!obs_ready_low) begin fails++; $display("FAIL ld_stall_ready: ls_ready rose during access"); end
    tests++; if (obs_wb_data !== 64'h1122_3344_5566_7788 || obs_wb_en !== 1'b1 || obs_wb_idx !== 5'd12) begin
      fails++; $display("FAIL ld_stall_wb: data=%h en=%b idx=%0d want 1122334455667788 1 12", obs_wb_data, obs_wb_en, obs_wb_idx);
    end
  endtask

  task automatic test_passthrough();
    run_txn(7'h00, 64'h1234, 64'h0, 64'h0, 1'b1, 5'd5, 0, 0);
    tests++; if (obs_lat != 2) begin fails++; $display("FAIL pass_latency: got %0d want 2", obs_lat); end
    tests++; if (obs_wb_data !== 64'h1234 || obs_wb_idx !== 5'd5 || obs_wb_en !== 1'b1 || obs_err !== 1'b0) begin
      fails++; $display("FAIL pass_wb: data=%h idx=%0d en=%b err=%b want 1234 5 1 0", obs_wb_data, obs_wb_idx, obs_wb_en, obs_err);
    end
    tests++; if (obs_req_seen) begin fails++; $display("FAIL pass_req: got request want none"); end
  endtask

  task automatic test_reset_mid();
    bit stray;
    @(negedge clk);
    ls_info = 7'h41; alu_res = 64'h100; rd_wr_en = 1; rd_idx = 5'd7; ls_valid = 1;
    @(posedge clk); #1;
    ls_valid = 0;
    @(negedge clk); mem_req_ready = 1;
    @(negedge clk); mem_req_ready = 0;
    tests++; if (mem_req_valid !== 1'b0 || ls_ready !== 1'b0) begin
      fails++; $display("FAIL rstmid_wait: req_valid=%b ls_ready=%b want 0 0", mem_req_valid, ls_ready);
    end
    rst = 1;
    @(negedge clk); rst = 0;
    tests++; if (ls_ready !== 1'b1) begin fails++; $display("FAIL rstmid_ready: got %b want 1", ls_ready); end
    mem_rsp_valid = 1; mem_rsp_rdata = 64'hDEAD_BEEF_0000_0001;
    @(negedge clk); mem_rsp_valid = 0;
    stray = 0;
    for (int i = 0; i < 6; i++) begin
      if (wb_valid) stray = 1;
      @(negedge clk);
    end
    tests++; if (stray) begin fails++; $display("FAIL rstmid_stray_wb: got wb_valid want none"); end
    tests++; if (ls_ready !== 1'b1 || mem_req_valid !== 1'b0) begin
      fails++; $display("FAIL rstmid_idle: ls_ready=%b req_valid=%b want 1 0", ls_ready, mem_req_valid);
    end
  endtask

  task automatic test_random();
    logic [6:0] info; logic [63:0] addr, rs2, rdata; logic rden; logic [4:0] idx;
    int rw, sw, sel, nb, e_lat;
    bit is_mem, e_err, e_wben; logic [63:0] e_data, e_wdata; logic [7:0] e_mask;
    for (int n = 0; n < 60; n++) begin
      sel = $urandom_range(0, 9);
      addr = {$urandom, $urandom};
      if (sel == 0) begin
        info = 7'($urandom);
      end else if (sel == 1) begin
        info = 7'($urandom) & 7'b1111100;
      end else begin
        info = '0;
        info[$urandom_range(0, 1)] = 1'b1;
        nb = $urandom_range(0, 3);
        info[3+nb] = 1'b1;
        info[2] = 1'($urandom);
        if ($urandom_range(0, 3) != 0) addr[2:0] = addr[2:0] & ~3'((1 << nb) - 1);
      end
      rs2 = {$urandom, $urandom}; rdata = {$urandom, $urandom};
      rden = 1'($urandom); idx = 5'($urandom);
      rw = $urandom_range(0, 3); sw = $urandom_range(0, 3);
      ref_model(info, addr, rs2, rdata, rden, is_mem, e_err, e_wben, e_data, e_mask, e_wdata);
      e_lat = is_mem ? 4 + rw + sw : 2;
      run_txn(info, addr, rs2, rdata, rden, idx, rw, sw);
      tests++; if (obs_req_seen != is_mem) begin
        fails++; $display("FAIL rnd%0d_req: got %b want %b (info=%h addr=%h)", n, obs_req_seen, is_mem, info, addr);
      end
      if (is_mem) begin
        tests++; if (obs_addr !== {addr[63:3], 3'b000} || obs_wen !== info[1] || obs_mask !== e_mask) begin
          fails++; $display("FAIL rnd%0d_fields: addr=%h wen=%b mask=%h want %h %b %h", n, obs_addr, obs_wen, obs_mask,
                            {addr[63:3], 3'b000}, info[1], e_mask);
        end
        tests++; if (!obs_stable || obs_req_cyc != rw + 1) begin
          fails++; $display("FAIL rnd%0d_hold: stable=%b cycles=%0d want 1 %0d", n, obs_stable, obs_req_cyc, rw + 1);
        end
        if (info[1]) begin
          tests++; if (obs_wdata !== e_wdata) begin fails++; $display("FAIL rnd%0d_wdata: got %h want %h", n, obs_wdata, e_wdata); end
        end
      end
      tests++; if (!obs_wb_seen || obs_lat != e_lat || obs_err !== e_err || obs_wb_en !== e_wben) begin
        fails++; $display("FAIL rnd%0d_wb: seen=%b lat=%0d err=%b en=%b want 1 %0d %b %b",
                          n, obs_wb_seen, obs_lat, obs_err, obs_wb_en, e_lat, e_err, e_wben);
      end
      if (!e_err) begin
        tests++; if (obs_wb_idx !== idx) begin fails++; $display("FAIL rnd%0d_idx: got %0d want %0d", n, obs_wb_idx, idx); end
      end
      if (!e_err && !info[1]) begin
        tests++; if (obs_wb_data !== e_data) begin fails++; $display("FAIL rnd%0d_data: got %h want %h (info=%h addr=%h)", n, obs_wb_data, e_data, info, addr); end
      end
      tests++; if (!obs_ready_low) begin fails++; $display("FAIL rnd%0d_ready: ls_ready rose during request", n); end
    end
  endtask

`ifdef YSYX_22040237_LSU_WATCHDOG_EN
  task automatic test_watchdog();
    run_txn(7'h41, 64'h200, 64'h0, 64'h0, 1'b1, 5'd3, 0, 100000);
    tests++; if (!obs_wb_seen || obs_err !== 1'b1 || obs_wb_en !== 1'b0 || obs_lat < 250 || obs_lat > 262) begin
      fails++; $display("FAIL watchdog: seen=%b err=%b en=%b lat=%0d want 1 1 0 ~258", obs_wb_seen, obs_err, obs_wb_en, obs_lat);
    end
  endtask
`endif

  initial begin
    rst = 1; ls_valid = 0; ls_info = '0; alu_res = '0; rs2_store = '0; rd_wr_en = 0; rd_idx = '0;
    mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_rdata = '0;
    test_reset();
    test_store_sb();
    test_load_ext();
    test_misaligned();
    test_stall();
    test_passthrough();
    test_reset_mid();
    test_passthrough();
    test_random();
`ifdef YSYX_22040237_LSU_WATCHDOG_EN
    test_watchdog();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
